max7219_matrix_emul: RTL and testbench

- Behavioural/synthesizable emulator of a daisy chain of G_NB_MATRIX MAX7219 8x8 LED drivers.
- Sits on the serial MAX7219 bus driven by the max7219 interface block, in the same clk domain.
- Captures the serial words and decodes them into per-device register files.
- Exposes the register contents through a readback port and protocol-error flags so a bench can check what was programmed.

---
 rtl/max7219_emul_pkg.sv | 29 ++
 rtl/max7219_matrix_emul_if.sv | 18 +
 rtl/max7219_emul_dev.sv | 26 ++
 rtl/max7219_matrix_emul.sv | 140 ++++++++++++++
 tb/tb_max7219_matrix_emul.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/max7219_emul_pkg.sv
// rtl/max7219_emul_pkg.sv - register map, word width and reg-file type shared by the MAX7219 emulator
package max7219_emul_pkg;

    localparam int WORD_W = 16;

    localparam logic [3:0] ADDR_NOOP      = 4'h0;
    localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
    localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
    localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
    localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
    localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
    localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
    localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
    localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
    localparam logic [3:0] ADDR_DECODE    = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY = 4'hA;
    localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
    localparam logic [3:0] ADDR_TEST      = 4'hF;

    typedef logic [15:0][7:0] reg_file_t;

    // 0xD and 0xE are holes in the MAX7219 map and behave like the no-op address
    function automatic logic addr_is_reg(input logic [3:0] addr);
        return (addr != ADDR_NOOP) && ((addr >= ADDR_DIGIT0 && addr <= ADDR_SHUTDOWN) ||
                                       (addr == ADDR_TEST));
    endfunction

endpackage

// File: rtl/max7219_matrix_emul_if.sv
// rtl/max7219_matrix_emul_if.sv - serial MAX7219 bus (clock, data, load) between driver and emulator
interface max7219_matrix_emul_if;
    logic i_max7219_clk;
    logic i_max7219_din;
    logic i_max7219_load;

    modport master (
        output i_max7219_clk,
        output i_max7219_din,
        output i_max7219_load
    );

    modport slave (
        input i_max7219_clk,
        input i_max7219_din,
        input i_max7219_load
    );
endinterface

// File: rtl/max7219_emul_dev.sv
// rtl/max7219_emul_dev.sv - one emulated MAX7219: 16x8 register file with write port and readback
module max7219_emul_dev
    import max7219_emul_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data
);

    reg_file_t regs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else if (wr_en && addr_is_reg(wr_addr)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data = addr_is_reg(rd_addr) ? regs[rd_addr] : 8'h00;

endmodule

// File: rtl/max7219_matrix_emul.sv
// rtl/max7219_matrix_emul.sv - MAX7219 daisy-chain emulator top; text dumps enabled by MAX7219_EMUL_DISPLAY_EN
module max7219_matrix_emul
    import max7219_emul_pkg::*;
#(
    parameter int G_NB_MATRIX = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    max7219_matrix_emul_if.slave bus,
    input  logic [7:0]           i_display_reg_matrix_n,
    input  logic                 i_display_screen_matrix,
    input  logic [2:0]           i_rd_matrix,
    input  logic [3:0]           i_rd_addr,
    output logic [7:0]           o_rd_data,
    output logic [15:0]          o_load_cnt,
    output logic                 o_frame_err
);

    localparam int FRAME_BITS = WORD_W * G_NB_MATRIX;

    logic                  sclk_s, sclk_p;
    logic                  din_s;
    logic                  load_s, load_p;
    logic                  sclk_edge, load_edge;
    logic                  frame_ok;
    logic [FRAME_BITS-1:0] shift_q;
    logic [7:0]            bit_cnt;
    logic [7:0]            dev_rd [G_NB_MATRIX];

    // The bus is produced in this clock domain, so a single sample stage suffices
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s <= 1'b0;
            sclk_p <= 1'b0;
            din_s  <= 1'b0;
            load_s <= 1'b0;
            load_p <= 1'b0;
        end else begin
            sclk_s <= bus.i_max7219_clk;
            sclk_p <= sclk_s;
            din_s  <= bus.i_max7219_din;
            load_s <= bus.i_max7219_load;
            load_p <= load_s;
        end
    end

    assign sclk_edge = sclk_s && !sclk_p;
    assign load_edge = load_s && !load_p;
    assign frame_ok  = (bit_cnt == 8'(FRAME_BITS));

    // A load edge implies load_s is high, so a coincident clock edge is dropped here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (load_edge) begin
            bit_cnt <= '0;
        end else if (sclk_edge && !load_s) begin
            shift_q <= {shift_q[FRAME_BITS-2:0], din_s};
            if (bit_cnt != 8'hFF) begin
                bit_cnt <= bit_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_load_cnt  <= '0;
            o_frame_err <= 1'b0;
        end else if (load_edge) begin
            if (o_load_cnt != 16'hFFFF) begin
                o_load_cnt <= o_load_cnt + 16'd1;
            end
            if (!frame_ok) begin
                o_frame_err <= 1'b1;
            end
        end
    end

`ifdef MAX7219_EMUL_DISPLAY_EN
    logic [7:0] disp_reg_p;
    logic       disp_scr_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_reg_p <= '0;
            disp_scr_p <= 1'b0;
        end else begin
            disp_reg_p <= i_display_reg_matrix_n;
            disp_scr_p <= i_display_screen_matrix;
        end
    end
`else
    logic unused_display;
    assign unused_display = ^{i_display_reg_matrix_n, i_display_screen_matrix};
`endif

    // Device k owns word k counted from the DIN end, i.e. the last word shifted lands in device 0
    for (genvar k = 0; k < G_NB_MATRIX; k++) begin : gen_dev
        max7219_emul_dev u_dev (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (load_edge && frame_ok),
            .wr_addr (shift_q[WORD_W*k+8 +: 4]),
            .wr_data (shift_q[WORD_W*k +: 8]),
            .rd_addr (i_rd_addr),
            .rd_data (dev_rd[k])
        );

`ifdef MAX7219_EMUL_DISPLAY_EN
        always @(posedge clk) begin : dump
            string row;
            if (rst_n && i_display_reg_matrix_n[k] && !disp_reg_p[k]) begin
                for (int a = 0; a < 16; a++) begin
                    $display("matrix %0d reg 0x%0h = 0x%02h", k, a, u_dev.regs[a]);
                end
            end
            if (rst_n && i_display_screen_matrix && !disp_scr_p) begin
                for (int r = 1; r <= 8; r++) begin
                    row = "";
                    for (int c = 7; c >= 0; c--) begin
                        row = {row, u_dev.regs[r][c] ? "#" : "."};
                    end
                    $display("matrix %0d row %0d %s", k, r, row);
                end
            end
        end
`endif
    end

    always_comb begin
        o_rd_data = 8'h00;
        for (int k = 0; k < G_NB_MATRIX; k++) begin
            if (i_rd_matrix == 3'(k)) begin
                o_rd_data = dev_rd[k];
            end
        end
    end

endmodule

// File: tb/tb_max7219_matrix_emul.sv
// tb/tb_max7219_matrix_emul.sv - self-checking bench for max7219_matrix_emul against a word-level model
module tb_max7219_matrix_emul;

    localparam int NB = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  disp_reg = '0;
    logic        disp_scr = 1'b0;
    logic [2:0]  rd_matrix = '0;
    logic [3:0]  rd_addr = '0;
    logic [7:0]  rd_data;
    logic [15:0] load_cnt;
    logic        frame_err;

    max7219_matrix_emul_if bus ();

    max7219_matrix_emul #(.G_NB_MATRIX(NB)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .bus                     (bus.slave),
        .i_display_reg_matrix_n  (disp_reg),
        .i_display_screen_matrix (disp_scr),
        .i_rd_matrix             (rd_matrix),
        .i_rd_addr               (rd_addr),
        .o_rd_data               (rd_data),
        .o_load_cnt              (load_cnt),
        .o_frame_err             (frame_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mdl_reg [NB][16];
    int          mdl_bits;
    int          mdl_loads;
    logic        mdl_err;
    logic [15:0] words [NB];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < NB; d++)
            for (int a = 0; a < 16; a++) mdl_reg[d][a] = 8'h00;
        mdl_bits  = 0;
        mdl_loads = 0;
        mdl_err   = 1'b0;
    endtask

    task automatic model_load();
        int a;
        mdl_loads = (mdl_loads == 65535) ? 65535 : mdl_loads + 1;
        if (mdl_bits != 16 * NB) begin
            mdl_err = 1'b1;
        end else begin
            for (int d = 0; d < NB; d++) begin
                a = int'(words[d][11:8]);
                if (a != 0 && a != 13 && a != 14) mdl_reg[d][a] = words[d][7:0];
            end
        end
        mdl_bits = 0;
    endtask

    task automatic check_state(input string tag);
        for (int d = 0; d < NB; d++) begin
            for (int a = 0; a < 16; a++) begin
                rd_matrix = 3'(d);
                rd_addr   = 4'(a);
                #1;
                chk($sformatf("%s rd[%0d][%0h]", tag, d, a), 16'(rd_data), 16'(mdl_reg[d][a]));
            end
        end
        chk({tag, " load_cnt"}, load_cnt, 16'(mdl_loads));
        chk({tag, " frame_err"}, 16'(frame_err), 16'(mdl_err));
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        bus.i_max7219_din = b;
        @(negedge clk);
        bus.i_max7219_clk = 1'b1;
        @(negedge clk);
        bus.i_max7219_clk = 1'b0;
        if (bus.i_max7219_load == 1'b0) mdl_bits++;
    endtask

    // Device NB-1 travels furthest, so its word is shifted first, MSB first
    task automatic send_frame(input int nbits);
        for (int i = 0; i < nbits; i++) begin
            send_bit(words[NB - 1 - i / 16][15 - i % 16]);
        end
    endtask

    task automatic do_load(input int clocks_while_high);
        @(negedge clk);
        bus.i_max7219_load = 1'b1;
        model_load();
        for (int i = 0; i < clocks_while_high; i++) begin
            send_bit(1'($urandom));
        end
        repeat (3) @(negedge clk);
        bus.i_max7219_load = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic random_words();
        for (int d = 0; d < NB; d++) words[d] = 16'($urandom);
    endtask

    initial begin
        bus.i_max7219_clk  = 1'b0;
        bus.i_max7219_din  = 1'b0;
        bus.i_max7219_load = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_state("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // full frame from the DIN-far device (0x0C01) down to device 0 (0x01A5)
        words[7] = 16'h0C01;
        words[0] = 16'h01A5;
        for (int d = 1; d < 7; d++) words[d] = 16'h0A00 | 16'(d);
        send_frame(16 * NB);
        do_load(0);
        check_state("full");
        chk("full reg7C", 16'(mdl_reg[7][12]), 16'h0001);

        for (int d = 0; d < NB; d++) words[d] = 16'h0B07;
        words[3] = 16'h0000;
        send_frame(16 * NB);
        do_load(0);
        check_state("noop");

        random_words();
        send_frame(40);
        do_load(0);
        check_state("short");
        random_words();
        send_frame(16 * NB);
        do_load(0);
        check_state("after_short");

        do_load(5);
        check_state("clk_in_load");
        random_words();
        send_frame(16 * NB);
        do_load(0);
        check_state("after_clk_in_load");

        for (int n = 0; n < 3; n++) begin
            random_words();
            send_frame(16 * NB);
            do_load(0);
            check_state($sformatf("rand%0d", n));
        end

        random_words();
        send_frame(9);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_state("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        random_words();
        send_frame(16 * NB);
        do_load(0);
        check_state("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
